// File: rtl/jk_pkg.sv
// Shared JK flip-flop definitions: command encoding and the single-bit next-state rule.
package jk_pkg;

  typedef enum logic [1:0] {
    JK_HOLD   = 2'b00,
    JK_RESET  = 2'b01,
    JK_SET    = 2'b10,
    JK_TOGGLE = 2'b11
  } jk_cmd_e;

  function automatic logic jk_next(input logic q, input logic j, input logic k);
    jk_cmd_e cmd;
    cmd = jk_cmd_e'({j, k});
    case (cmd)
      JK_HOLD:   return q;
      JK_RESET:  return 1'b0;
      JK_SET:    return 1'b1;
      JK_TOGGLE: return ~q;
      default:   return q;
    endcase
  endfunction

endpackage

// File: rtl/jk_stage.sv
// One JK flip-flop bit with synchronous active-high reset to 0.
module jk_stage
  import jk_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic j,
  input  logic k,
  output logic q
);

  always_ff @(posedge clk) begin
    if (rst) q <= 1'b0;
    else     q <= jk_next(q, j, k);
  end

endmodule

// File: rtl/jk_mod_counter.sv
// Up/down modulo-MOD counter whose state lives in a bank of JK stages driven by
// minimal J/K excitation derived from the wanted next count.
module jk_mod_counter #(
  parameter int W   = 4,
  parameter int MOD = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         up,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] q,
  output logic         tc,
  output logic         load_err,
  output logic [W-1:0] j_vec,
  output logic [W-1:0] k_vec
);

  if (W < 2 || W > 16) begin : g_bad_w
    $error("jk_mod_counter: W=%0d outside 2..16", W);
  end
  if (MOD < 2 || MOD > (1 << W)) begin : g_bad_mod
    $error("jk_mod_counter: MOD=%0d outside 2..2**W", MOD);
  end

  localparam logic [W-1:0] MAX     = W'(MOD - 1);
  // One extra bit so MOD == 2**W still compares correctly.
  localparam logic [W:0]   MOD_EXT = (W+1)'(MOD);

  logic [W-1:0] nxt;
  logic         in_range;

  always_comb begin
    in_range = ({1'b0, load_val} < MOD_EXT);
    nxt      = q;
    if (load) begin
      nxt = in_range ? load_val : MAX;
    end else if (en) begin
      if (up) nxt = (q == MAX)   ? '0  : q + W'(1);
      else    nxt = (q == '0)    ? MAX : q - W'(1);
    end
  end

  // Minimal excitation: only bits that must change get J or K, never both.
  assign j_vec = nxt & ~q;
  assign k_vec = ~nxt & q;

  assign tc = en & ~load & ~rst & (up ? (q == MAX) : (q == '0));

  for (genvar i = 0; i < W; i++) begin : g_bit
    jk_stage u_stage (
      .clk (clk),
      .rst (rst),
      .j   (j_vec[i]),
      .k   (k_vec[i]),
      .q   (q[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) load_err <= 1'b0;
    else     load_err <= load & ~in_range;
  end

endmodule

// File: tb/tb_jk_mod_counter.sv
// Bench for jk_mod_counter: a W=4/MOD=10 and a W=3/MOD=8 instance share stimulus and
// are compared every cycle against an integer modular-arithmetic model.
module tb_jk_mod_counter;

  logic       clk = 1'b0;
  logic       rst, en, up, load;
  logic [3:0] load_val;
  logic [2:0] load_val8;

  logic [3:0] q_a, j_a, k_a;
  logic       tc_a, err_a;
  logic [2:0] q_b, j_b, k_b;
  logic       tc_b, err_b;

  int n_checks = 0;
  int n_fail   = 0;

  int  ma_q, mb_q;
  bit  ma_err, mb_err;
  bit  inited = 1'b0;

  always #5 clk = ~clk;

  jk_mod_counter #(.W(4), .MOD(10)) dut (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
    .q(q_a), .tc(tc_a), .load_err(err_a), .j_vec(j_a), .k_vec(k_a)
  );

  jk_mod_counter #(.W(3), .MOD(8)) dut8 (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val8),
    .q(q_b), .tc(tc_b), .load_err(err_b), .j_vec(j_b), .k_vec(k_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int model_nxt(input int cur, input int m, input bit l, input int lv,
                                   input bit e, input bit u);
    if (l)      return (lv < m) ? lv : m - 1;
    else if (e) return u ? (cur + 1) % m : (cur + m - 1) % m;
    else        return cur;
  endfunction

  task automatic cycle(input bit r, input bit l, input int lv, input bit e, input bit u);
    int na, nb;
    bit tca, tcb;
    rst = r; load = l; load_val = 4'(lv); load_val8 = 3'(lv); en = e; up = u;
    na  = model_nxt(ma_q, 10, l, lv, e, u);
    nb  = model_nxt(mb_q, 8, l, lv % 8, e, u);
    tca = e && !l && !r && (u ? ma_q == 9 : ma_q == 0);
    tcb = e && !l && !r && (u ? mb_q == 7 : mb_q == 0);
    @(negedge clk);
    if (inited) begin
      check("a_tc", tc_a, tca);
      check("a_j",  j_a, na & ~ma_q & 4'hf);
      check("a_k",  k_a, ~na & ma_q & 4'hf);
      check("b_tc", tc_b, tcb);
      check("b_j",  j_b, nb & ~mb_q & 3'h7);
      check("b_k",  k_b, ~nb & mb_q & 3'h7);
    end
    @(posedge clk);
    #1;
    ma_q   = r ? 0 : na;
    ma_err = !r && l && (lv >= 10);
    mb_q   = r ? 0 : nb;
    mb_err = 1'b0;
    if (r) inited = 1'b1;
    if (inited) begin
      check("a_q",   q_a, ma_q);
      check("a_err", err_a, ma_err);
      check("b_q",   q_b, mb_q);
      check("b_err", err_b, mb_err);
    end
  endtask

  initial begin
    ma_q = 0; mb_q = 0; ma_err = 0; mb_err = 0;
    rst = 1; en = 0; up = 1; load = 0; load_val = '0; load_val8 = '0;
    #1;

    // Reset then count up through the wrap.
    cycle(1, 0, 0, 0, 1);
    cycle(1, 0, 0, 0, 1);
    check("rst_q", q_a, 0);
    check("rst_err", err_a, 0);
    for (int i = 0; i < 12; i++) cycle(0, 0, 0, 1, 1);

    // Load 3 and count down through underflow.
    cycle(0, 1, 3, 0, 0);
    for (int i = 0; i < 5; i++) cycle(0, 0, 0, 1, 0);

    // Out-of-range load clamps, then in-range load.
    cycle(0, 1, 13, 0, 1);
    check("clamp_q", q_a, 9);
    check("clamp_err", err_a, 1);
    cycle(0, 1, 7, 0, 1);
    check("load7_err", err_a, 0);

    // Priority: reset beats load and en; load beats en.
    cycle(0, 1, 5, 0, 1);
    cycle(1, 1, 5, 1, 1);
    check("prio_rst_q", q_a, 0);
    cycle(0, 1, 2, 1, 1);
    check("prio_load_q", q_a, 2);

    // Hold at 6, then reverse direction mid-run.
    cycle(0, 1, 6, 0, 1);
    for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0, 1);
    cycle(0, 0, 0, 1, 1);
    cycle(0, 0, 0, 1, 0);
    cycle(0, 0, 0, 1, 0);

    // Full-range instance: load 7 (also legal for MOD=10) and wrap upward.
    cycle(0, 1, 7, 0, 1);
    cycle(0, 0, 0, 1, 1);
    check("full_wrap_q", q_b, 0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 39) == 0), ($urandom_range(0, 7) == 0),
            int'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule

// File: doc/jk_mod_counter.md
Name: jk_mod_counter

Overview:
- Synchronous up/down modulo-N counter whose state bits are held in JK flip-flop stages, one per bit.
- Sits directly downstream of the single JK flip-flop cell and consumes it: this block computes the J/K excitation for every bit each cycle and stores the state in a bank of JK stages.
- Used as the team's reference for JK excitation design, and as a reusable BCD/modulo counter for display and timing projects.

Parameters:
- W, 4, counter width in bits; legal range 2..16.
- MOD, 10, count modulus; the count runs 0..MOD-1; legal range 2..2**W.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous active-high reset.
- en  input  1  count enable; the counter advances one step per cycle while high.
- up  input  1  count direction: 1 = increment, 0 = decrement.
- load  input  1  synchronous parallel load; overrides en.
- load_val  input  W  value to load.
- q  output  W  current count; this is the state of the JK bank.
- tc  output  1  terminal count: combinational, high when the next edge wraps the count.
- load_err  output  1  registered one-cycle flag: the last load value was out of range and was clamped.
- j_vec  output  W  J excitation currently applied to each bit (debug/observation).
- k_vec  output  W  K excitation currently applied to each bit (debug/observation).

Behaviour:
- Reset. Clock and reset: one clock (clk); reset is synchronous and active-high (rst). When rst is sampled high at a clk edge, q=0 and load_err=0 after that edge. Reset overrides load and en. Reset asserted mid-count lands on 0 at the same edge, with no partial update.
- Priority at each edge: rst > load > en > hold.
- Target value nxt, computed combinationally:
  - load: nxt = load_val if load_val < MOD; otherwise nxt = MOD-1 and load_err is 1 for exactly the following cycle.
  - en with up=1: nxt = 0 if q == MOD-1, else q+1.
  - en with up=0: nxt = MOD-1 if q == 0, else q-1.
  - neither load nor en: nxt = q.
- Excitation per bit i (minimal form):
  - j_vec[i] = nxt[i] & ~q[i]
  - k_vec[i] = ~nxt[i] & q[i]
  - Hold therefore gives J=K=0; no bit ever sees J=K=1.
- JK stage at each edge: J=0,K=0 hold; J=1 sets; K=1 clears; J=K=1 toggles. Toggle is implemented but never exercised by this block.
- Latency: q reflects nxt one edge after the inputs are sampled. No multi-cycle operations.
- tc = en & ~load & ~rst & (up ? q == MOD-1 : q == 0).
- load_err clears on the next edge unless another out-of-range load occurs.
- Width rules:
  - All arithmetic is W bits wide.
  - The MOD-1 comparison is evaluated at elaboration.
  - When MOD == 2**W, the wrap happens naturally and out-of-range loads are impossible, so load_err stays 0.
- Simultaneous events:
  - load together with en: load wins and tc=0.
  - up changing while en=1 takes effect at the next edge, with no glitch on q.
- No X-propagation is tolerated on q after the first reset.

Decomposition:
- Shared package jk_pkg:
  - typedef of the JK command encoding (HOLD=00, RESET=01, SET=10, TOGGLE=11).
  - helper function jk_next(q, j, k).
- Sub-module jk_stage, instantiated W times in a generate loop:
  - ports clk, rst, j, k, q.
  - synchronous active-high reset to 0.
  - same JK semantics as the existing flip-flop cell.
- Elaboration-time assertions check the MOD and W ranges.

Test Plan:
- Reset and count up: rst high for 2 cycles, then en=1, up=1 for 12 cycles with W=4, MOD=10 -> q goes 0..9, then 0, 1; tc high only while q=9; j_vec=4'b0001 at q=0.
- Count down and underflow: load 3 then en=1, up=0 -> q goes 3, 2, 1, 0, 9, 8; tc high while q=0; at q=0 the excitation is j_vec=4'b1001, k_vec=4'b0000.
- Out-of-range load: load=1, load_val=13 -> q=9 next cycle, load_err=1 for one cycle only; load_val=7 -> q=7, load_err=0.
- Priority: rst=1, load=1, en=1 at q=5 -> q=0; load=1, en=1, load_val=2 -> q=2, tc=0 that cycle.
- Hold: en=0 for 5 cycles at q=6 -> q stays 6, j_vec=k_vec=0, tc=0; toggle up mid-run -> direction changes at the next edge.
- Full-range modulus, W=3, MOD=8: count up from 7 -> q=0 with tc=1; load 7 -> load_err stays 0.
